// File: rtl/mem_arbiter.sv
// Multi-channel memory arbiter: grants one requesting master at a time to a single memory port.
// Define MEM_ARB_FIXED_PRIORITY_EN for fixed priority (lowest channel wins); default is round-robin.
`timescale 1ns/1ps

module mem_arbiter #(
  parameter int CHANNELS = 2,
  parameter int AWIDTH   = 22,
  parameter int DWIDTH   = 36,
  parameter int TIMEOUT  = 64
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [CHANNELS*AWIDTH-1:0]   m_addr,
  input  logic [CHANNELS*DWIDTH-1:0]   m_write_data,
  input  logic [CHANNELS-1:0]          m_read,
  input  logic [CHANNELS-1:0]          m_write,
  output logic [CHANNELS-1:0]          m_read_ack,
  output logic [CHANNELS-1:0]          m_write_ack,
  output logic [CHANNELS-1:0]          m_nxm,
  output logic [DWIDTH-1:0]            m_read_data,
  output logic [AWIDTH-1:0]            mem_addr,
  output logic [DWIDTH-1:0]            mem_write_data,
  output logic                         mem_read,
  output logic                         mem_write,
  input  logic [DWIDTH-1:0]            mem_read_data,
  input  logic                         mem_read_ack,
  input  logic                         mem_write_ack,
  output logic [1:0]                   dbg_state
);

  localparam int IW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RELEASE = 2'd2
  } state_t;

  // Handshake: a master holds m_read/m_write (level) until it sees its one-cycle
  // ack; downstream, mem_read/mem_write stay high until the matching mem ack.
  state_t                state_q;
  logic [CHANNELS-1:0]   gnt_oh_q;
  logic                  op_write_q;
  logic [CW-1:0]         wait_q;
  logic [AWIDTH-1:0]     addr_q;
  logic [DWIDTH-1:0]     wdata_q;
  logic                  rd_q;
  logic                  wr_q;
  logic [CHANNELS-1:0]   rack_q;
  logic [CHANNELS-1:0]   wack_q;
  logic [CHANNELS-1:0]   nxm_q;
  logic [DWIDTH-1:0]     rdata_q;
`ifndef MEM_ARB_FIXED_PRIORITY_EN
  logic [IW-1:0]         last_q;
  logic [IW-1:0]         pick_hi;
  logic                  found_hi;
`endif

  logic [CHANNELS-1:0]   req;
  logic [IW-1:0]         pick_lo;
  logic                  found_lo;
  logic [IW-1:0]         next_grant;
  logic [CHANNELS-1:0]   next_oh;
  logic [AWIDTH-1:0]     sel_addr;
  logic [DWIDTH-1:0]     sel_wdata;
  logic                  sel_write;
  logic                  ack_match;

  assign req = m_read | m_write;

  // Round-robin: first requester above the last grant, otherwise the lowest requester.
  always_comb begin
    pick_lo  = '0;
    found_lo = 1'b0;
`ifndef MEM_ARB_FIXED_PRIORITY_EN
    pick_hi  = '0;
    found_hi = 1'b0;
`endif
    for (int i = 0; i < CHANNELS; i++) begin
      if (req[i] && !found_lo) begin
        pick_lo  = IW'(i);
        found_lo = 1'b1;
      end
`ifndef MEM_ARB_FIXED_PRIORITY_EN
      if (req[i] && !found_hi && (IW'(i) > last_q)) begin
        pick_hi  = IW'(i);
        found_hi = 1'b1;
      end
`endif
    end
`ifdef MEM_ARB_FIXED_PRIORITY_EN
    next_grant = pick_lo;
`else
    next_grant = found_hi ? pick_hi : pick_lo;
`endif
  end

  always_comb begin
    next_oh   = '0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (IW'(i) == next_grant) begin
        next_oh[i] = |req;
        sel_addr   = m_addr[i*AWIDTH +: AWIDTH];
        sel_wdata  = m_write_data[i*DWIDTH +: DWIDTH];
      end
    end
  end

  // A channel raising both strobes is treated as a write.
  assign sel_write = |(m_write & next_oh);
  assign ack_match = op_write_q ? mem_write_ack : mem_read_ack;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      gnt_oh_q   <= '0;
      op_write_q <= 1'b0;
      wait_q     <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      rack_q     <= '0;
      wack_q     <= '0;
      nxm_q      <= '0;
      rdata_q    <= '0;
`ifndef MEM_ARB_FIXED_PRIORITY_EN
      last_q     <= IW'(CHANNELS - 1);
`endif
    end else begin
      rack_q <= '0;
      wack_q <= '0;
      nxm_q  <= '0;
      case (state_q)
        IDLE: begin
          rdata_q <= '0;
          if (|req) begin
            gnt_oh_q   <= next_oh;
            op_write_q <= sel_write;
            addr_q     <= sel_addr;
            wdata_q    <= sel_wdata;
            rd_q       <= !sel_write;
            wr_q       <= sel_write;
            wait_q     <= '0;
            state_q    <= BUSY;
`ifndef MEM_ARB_FIXED_PRIORITY_EN
            last_q     <= next_grant;
`endif
          end
        end
        BUSY: begin
          if (ack_match) begin
            rdata_q <= op_write_q ? '0 : mem_read_data;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            rack_q  <= op_write_q ? '0 : gnt_oh_q;
            wack_q  <= op_write_q ? gnt_oh_q : '0;
            state_q <= RELEASE;
          end else if (wait_q == WAIT_LAST) begin
            // No memory answered: complete the cycle flagged as non-existent memory.
            rdata_q <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            rack_q  <= op_write_q ? '0 : gnt_oh_q;
            wack_q  <= op_write_q ? gnt_oh_q : '0;
            nxm_q   <= gnt_oh_q;
            state_q <= RELEASE;
          end else begin
            wait_q <= wait_q + 1'b1;
          end
        end
        RELEASE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Outputs read as zero while reset is held, even before the first clock edge.
  assign m_read_ack     = reset ? '0 : rack_q;
  assign m_write_ack    = reset ? '0 : wack_q;
  assign m_nxm          = reset ? '0 : nxm_q;
  assign m_read_data    = reset ? '0 : rdata_q;
  assign mem_addr       = reset ? '0 : addr_q;
  assign mem_write_data = reset ? '0 : wdata_q;
  assign mem_read       = reset ? 1'b0 : rd_q;
  assign mem_write      = reset ? 1'b0 : wr_q;
  assign dbg_state      = reset ? 2'b00 : state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: memory model, response scoreboard, directed and random traffic.
`timescale 1ns/1ps

module tb_mem_arbiter;

  localparam int CH = 2;
  localparam int AW = 22;
  localparam int DW = 36;
  localparam int TO = 64;
  localparam int RW = 3 + 1 + 1 + AW + DW;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [CH*AW-1:0] m_addr = '0;
  logic [CH*DW-1:0] m_write_data = '0;
  logic [CH-1:0]    m_read = '0;
  logic [CH-1:0]    m_write = '0;
  logic [CH-1:0]    m_read_ack, m_write_ack, m_nxm;
  logic [DW-1:0]    m_read_data;
  logic [AW-1:0]    mem_addr;
  logic [DW-1:0]    mem_write_data;
  logic             mem_read, mem_write;
  logic [DW-1:0]    mem_read_data = '0;
  logic             mem_read_ack = 1'b0;
  logic             mem_write_ack = 1'b0;
  logic [1:0]       dbg_state;

  mem_arbiter #(.CHANNELS(CH), .AWIDTH(AW), .DWIDTH(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .m_addr(m_addr), .m_write_data(m_write_data),
    .m_read(m_read), .m_write(m_write),
    .m_read_ack(m_read_ack), .m_write_ack(m_write_ack), .m_nxm(m_nxm),
    .m_read_data(m_read_data),
    .mem_addr(mem_addr), .mem_write_data(mem_write_data),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_read_data(mem_read_data), .mem_read_ack(mem_read_ack), .mem_write_ack(mem_write_ack),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic check_quiet(input string tag);
    check_val({tag, "_ctl"}, {m_read_ack, m_write_ack, m_nxm, mem_read, mem_write}, 0);
    check_val({tag, "_addr"}, mem_addr, 0);
    check_val({tag, "_rdata"}, m_read_data, 0);
    check_val({tag, "_wdata"}, mem_write_data, 0);
  endtask

  function automatic logic [RW-1:0] mk_rec(input int ch, input bit wr, input bit nxm,
                                           input logic [AW-1:0] a, input logic [DW-1:0] d);
    return {3'(ch), wr, nxm, a, d};
  endfunction

  // ---------------- memory model ----------------
  int              mem_lat = 1;
  bit              mem_hang = 0;
  bit              mem_spurious = 0;
  logic [DW-1:0]   rd_word = '0;
  int              mem_cnt = 0;
  logic [AW-1:0]   seen_addr = '0;
  logic [DW-1:0]   seen_wdata = '0;

  always @(negedge clk) begin
    mem_read_ack  = 1'b0;
    mem_write_ack = 1'b0;
    if (mem_read || mem_write) begin
      seen_addr  = mem_addr;
      seen_wdata = mem_write_data;
      if (mem_spurious && mem_cnt == 0) begin
        mem_read_ack  = mem_write;
        mem_write_ack = mem_read;
      end
      if (!mem_hang && mem_cnt == mem_lat) begin
        mem_read_ack  = mem_read;
        mem_write_ack = mem_write;
      end else begin
        mem_cnt++;
      end
    end else begin
      mem_cnt = 0;
    end
    mem_read_data = mem_read_ack ? rd_word : ~rd_word;
  end

  // ---------------- scoreboard ----------------
  logic [RW-1:0] exp_q[$];
  bit gap_en = 0;
  int exp_gap = 0;
  int last_ack_cyc = -1;

  always @(negedge clk) begin
    logic [CH-1:0] acks;
    logic [RW-1:0] act, exp;
    int            ch;
    logic          wr;
    if (!reset) begin
      acks = m_read_ack | m_write_ack;
      if (|(acks | m_nxm)) begin
        check_val("ack_onehot", $countones(acks), 1);
        check_val("nxm_without_ack", m_nxm & ~acks, 0);
        ch = 0;
        for (int i = CH - 1; i >= 0; i--) if (acks[i]) ch = i;
        wr  = |m_write_ack;
        act = mk_rec(ch, wr, m_nxm[ch], seen_addr, wr ? seen_wdata : m_read_data);
        check_val("expect_pending", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          exp = exp_q.pop_front();
          check_val("sb_resp", act, exp);
        end
        if (gap_en && last_ack_cyc >= 0) check_val("ack_gap", cyc - last_ack_cyc, exp_gap);
        last_ack_cyc = cyc;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_req(input int ch, input bit rd, input bit wr, input logic [AW-1:0] a,
                           input logic [DW-1:0] wd, input bit push, input bit exp_nxm,
                           input logic [DW-1:0] exp_rdata);
    m_addr[ch*AW +: AW]       = a;
    m_write_data[ch*DW +: DW] = wd;
    m_read[ch]                = rd;
    m_write[ch]               = wr;
    if (push) exp_q.push_back(mk_rec(ch, wr, exp_nxm, a, wr ? wd : exp_rdata));
  endtask

  task automatic wait_ack(input int ch, input int lat0, output int lat, output int strobes);
    bit got;
    got = 0;
    lat = lat0;
    strobes = 0;
    for (int k = 0; k < 200 && !got; k++) begin
      @(negedge clk);
      lat++;
      if (mem_read || mem_write) strobes++;
      if (m_read_ack[ch] || m_write_ack[ch]) got = 1;
    end
    m_read[ch]  = 1'b0;
    m_write[ch] = 1'b0;
    check_val("ack_seen", got, 1);
  endtask

  task automatic one_txn(input string tag, input int ch, input bit rd, input bit wr,
                         input logic [AW-1:0] a, input logic [DW-1:0] wd, input int lat);
    int got_lat, sc;
    mem_lat = lat;
    start_req(ch, rd, wr, a, wd, 1, 0, rd_word);
    wait_ack(ch, 0, got_lat, sc);
    check_val(tag, got_lat, lat + 2);
    @(negedge clk);
  endtask

  task automatic hold_two(input int ch);
    int cnt;
    cnt = 0;
    for (int k = 0; k < 200 && cnt < 2; k++) begin
      @(negedge clk);
      if (m_read_ack[ch] || m_write_ack[ch]) cnt++;
    end
    m_write[ch] = 1'b0;
    m_read[ch]  = 1'b0;
    check_val("contention_acks", cnt, 2);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat, sc, l0, l1, s0, s1, op;
    logic [DW-1:0] d0, d1;

    // Reset: outputs quiet during and right after reset.
    repeat (3) @(negedge clk);
    check_quiet("rst_during");
    reset = 1'b0;
    #1;
    check_quiet("rst_after");
    check_val("rst_state", dbg_state, 0);
    @(negedge clk);

    // Single read, memory latency 3.
    mem_lat = 3;
    rd_word = 36'o123456701234;
    start_req(0, 1, 0, 22'o1000, '0, 1, 0, rd_word);
    @(negedge clk);
    check_val("strobe_next_cycle", {mem_read, mem_write}, 2'b10);
    check_val("mem_addr_issued", mem_addr, 22'o1000);
    check_val("busy_state", dbg_state, 1);
    wait_ack(0, 1, lat, sc);
    check_val("read_latency", lat, 5);
    check_val("read_strobe_cycles", sc, 3);
    @(negedge clk);

    // Read+write together is a write.
    one_txn("rw_latency", 0, 1, 1, 22'o2345, 36'o777777777777, 2);

    // Mismatched memory acks must be ignored.
    mem_spurious = 1;
    rd_word = 36'o111122223333;
    one_txn("spur_wr_latency", 1, 0, 1, 22'o3001, 36'o444455556666, 3);
    one_txn("spur_rd_latency", 0, 1, 0, 22'o3002, '0, 2);
    mem_spurious = 0;

    // Random single transactions.
    for (int n = 0; n < 10; n++) begin
      op      = $urandom_range(0, 2);
      rd_word = DW'({$urandom(), $urandom()});
      one_txn("rand_latency", $urandom_range(0, CH - 1), op != 1, op != 0,
              AW'($urandom()), DW'({$urandom(), $urandom()}), $urandom_range(0, 5));
    end

    // Timeout on ch1: memory never answers.
    mem_hang = 1;
    start_req(1, 1, 0, 22'o7700, '0, 1, 1, '0);
    wait_ack(1, 0, lat, sc);
    check_val("timeout_latency", lat, TO + 1);
    check_val("timeout_strobe_cycles", sc, TO);
    @(negedge clk);

    // Reset in BUSY: cycle aborted, ch0 wins first after reset.
    start_req(0, 1, 0, 22'o1111, '0, 0, 0, '0);
    start_req(1, 1, 0, 22'o2222, '0, 0, 0, '0);
    repeat (4) @(negedge clk);
    check_val("busy_before_reset", {dbg_state, mem_read}, {2'd1, 1'b1});
    reset = 1'b1;
    #1;
    check_quiet("rst_mid_during");
    @(negedge clk);
    check_quiet("rst_mid_held");
    check_val("rst_mid_state", dbg_state, 0);
    mem_hang = 0;
    mem_lat  = 1;
    rd_word  = 36'o555000555;
    exp_q.push_back(mk_rec(0, 0, 0, 22'o1111, rd_word));
    exp_q.push_back(mk_rec(1, 0, 0, 22'o2222, rd_word));
    reset = 1'b0;
    #1;
    check_quiet("rst_mid_after");
    fork
      wait_ack(0, 0, l0, s0);
      wait_ack(1, 0, l1, s1);
    join
    check_val("post_rst_ch0_latency", l0, 3);
    check_val("post_rst_ch1_latency", l1, 7);
    @(negedge clk);

    // Contention: both channels write continuously.
    mem_lat = 2;
    d0 = 36'o101010101010;
    d1 = 36'o202020202020;
    exp_gap = 5;
    last_ack_cyc = -1;
    gap_en = 1;
`ifdef MEM_ARB_FIXED_PRIORITY_EN
    exp_q.push_back(mk_rec(0, 1, 0, 22'o100, d0));
    exp_q.push_back(mk_rec(0, 1, 0, 22'o100, d0));
    exp_q.push_back(mk_rec(1, 1, 0, 22'o200, d1));
    exp_q.push_back(mk_rec(1, 1, 0, 22'o200, d1));
`else
    exp_q.push_back(mk_rec(0, 1, 0, 22'o100, d0));
    exp_q.push_back(mk_rec(1, 1, 0, 22'o200, d1));
    exp_q.push_back(mk_rec(0, 1, 0, 22'o100, d0));
    exp_q.push_back(mk_rec(1, 1, 0, 22'o200, d1));
`endif
    start_req(0, 0, 1, 22'o100, d0, 0, 0, '0);
    start_req(1, 0, 1, 22'o200, d1, 0, 0, '0);
    fork
      hold_two(0);
      hold_two(1);
    join
    gap_en = 0;
    repeat (3) @(negedge clk);

    check_val("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
